// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with a shared prescaler and period counter, double-buffered duty.
// Define PWM_CENTER_ALIGN_EN to add center-aligned (up/down) counting selected by 'mode'.
module pwm_multi #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 8,
    parameter int PRE_W  = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [PRE_W-1:0]        prescale,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic                    duty_load,
    input  logic [NUM_CH-1:0]       polarity,
    input  logic                    mode,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_start,
    output logic                    duty_pending
);

    logic [PRE_W-1:0]        pre_cnt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [NUM_CH*CNT_W-1:0] active_duty;
    logic [NUM_CH*CNT_W-1:0] shadow_duty;
    logic [NUM_CH-1:0]       pwm_nxt;
    logic                    tick;
    logic                    wrap;
`ifdef PWM_CENTER_ALIGN_EN
    logic                    dir;
    logic                    dir_nxt;
`else
    logic                    mode_unused;
    assign mode_unused = mode;
`endif

    always_comb begin
        tick    = enable && (pre_cnt >= prescale);
        cnt_nxt = cnt;
        wrap    = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_nxt = dir;
`endif
        if (tick) begin
`ifdef PWM_CENTER_ALIGN_EN
            // Down-count (or reversal) that lands on 0 is the period boundary.
            if (mode) begin
                if (!dir && (cnt < period)) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end else if (cnt <= CNT_W'(1)) begin
                    cnt_nxt = '0;
                    dir_nxt = 1'b0;
                    wrap    = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    dir_nxt = 1'b1;
                end
            end else begin
                dir_nxt = 1'b0;
                if (cnt >= period) begin
                    cnt_nxt = '0;
                    wrap    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
`else
            if (cnt >= period) begin
                cnt_nxt = '0;
                wrap    = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
`endif
        end
    end

    always_comb begin
        pwm_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_nxt[i] = (cnt < active_duty[i*CNT_W +: CNT_W]) ^ polarity[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt      <= '0;
            cnt          <= '0;
            active_duty  <= '0;
            shadow_duty  <= '0;
            pwm_out      <= '0;
            period_start <= 1'b0;
            duty_pending <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir          <= 1'b0;
`endif
        end else if (!enable) begin
            // Idle: loads bypass the shadow; a leftover shadow is promoted so both stay equal.
            pre_cnt      <= '0;
            cnt          <= '0;
            pwm_out      <= polarity;
            period_start <= 1'b0;
            duty_pending <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir          <= 1'b0;
`endif
            if (duty_load) begin
                active_duty <= duty;
                shadow_duty <= duty;
            end else begin
                active_duty <= shadow_duty;
            end
        end else begin
            pre_cnt      <= tick ? '0 : pre_cnt + PRE_W'(1);
            cnt          <= cnt_nxt;
            period_start <= wrap;
            pwm_out      <= pwm_nxt;
`ifdef PWM_CENTER_ALIGN_EN
            dir          <= dir_nxt;
`endif
            if (wrap) begin
                active_duty  <= shadow_duty;
                duty_pending <= duty_load;
                if (duty_load) begin
                    shadow_duty <= duty;
                end
            end else if (duty_load) begin
                shadow_duty  <= duty;
                duty_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: randomized and directed stimulus against a period-position reference model,
// with expected outputs queued per clock and checked by an independent monitor.
module tb_pwm_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int PRE_W  = 32;

    logic                    clk;
    logic                    reset_n;
    logic                    enable;
    logic [PRE_W-1:0]        prescale;
    logic [CNT_W-1:0]        period;
    logic [NUM_CH*CNT_W-1:0] duty;
    logic                    duty_load;
    logic [NUM_CH-1:0]       polarity;
    logic                    mode;
    logic [NUM_CH-1:0]       pwm_out;
    logic                    period_start;
    logic                    duty_pending;

    typedef struct {
        logic [NUM_CH-1:0] pwm;
        logic              ps;
        logic              pend;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: position within the current period plus prescaler phase.
    int m_pre;
    int m_pos;
    int m_active[NUM_CH];
    int m_shadow[NUM_CH];
    bit m_pend;

    pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .prescale     (prescale),
        .period       (period),
        .duty         (duty),
        .duty_load    (duty_load),
        .polarity     (polarity),
        .mode         (mode),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty_pending (duty_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int cntOf(input int pos, input int per, input bit center);
        return (center && pos > per) ? 2 * per - pos : pos;
    endfunction

    function automatic void modelReset();
        m_pre  = 0;
        m_pos  = 0;
        m_pend = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_active[i] = 0;
            m_shadow[i] = 0;
        end
    endfunction

    // Drive one clock of inputs, predict the outputs after the next rising edge.
    task automatic applyStimulus(input bit en, input int pre, input int per, input bit ld,
                                 input logic [NUM_CH*CNT_W-1:0] d, input logic [NUM_CH-1:0] pol,
                                 input bit md);
        exp_t e;
        bit   center;
        bit   tk;
        bit   wr;
        int   len;
        int   c;
        enable    = en;
        prescale  = PRE_W'(pre);
        period    = CNT_W'(per);
        duty      = d;
        duty_load = ld;
        polarity  = pol;
        mode      = md;
`ifdef PWM_CENTER_ALIGN_EN
        center = md;
`else
        center = 1'b0;
`endif
        len = center ? ((per == 0) ? 1 : 2 * per) : per + 1;
        if (!en) begin
            e.pwm  = pol;
            e.ps   = 1'b0;
            e.pend = 1'b0;
            m_pre  = 0;
            m_pos  = 0;
            m_pend = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_active[i] = ld ? int'(d[i*CNT_W +: CNT_W]) : m_shadow[i];
                m_shadow[i] = m_active[i];
            end
        end else begin
            c = cntOf(m_pos, per, center);
            for (int i = 0; i < NUM_CH; i++) begin
                e.pwm[i] = (c < m_active[i]) ^ pol[i];
            end
            tk = (m_pre >= pre);
            wr = 1'b0;
            if (tk) begin
                m_pre = 0;
                m_pos = (m_pos + 1) % len;
                wr    = (m_pos == 0);
            end else begin
                m_pre++;
            end
            if (wr) begin
                for (int i = 0; i < NUM_CH; i++) m_active[i] = m_shadow[i];
                m_pend = ld;
            end else if (ld) begin
                m_pend = 1'b1;
            end
            if (ld) begin
                for (int i = 0; i < NUM_CH; i++) m_shadow[i] = int'(d[i*CNT_W +: CNT_W]);
            end
            e.ps   = wr;
            e.pend = m_pend;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between clock edges, outputs checked while reset is low.
    task automatic pulseReset();
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_pwm", int'(pwm_out), 0);
        checkOutput("async_rst_ps", int'(period_start), 0);
        checkOutput("async_rst_pend", int'(duty_pending), 0);
        #1;
        reset_n = 1'b1;
        modelReset();
    endtask

    // Load config while idle, then run enabled; optional mid-run load at cycle ldAt.
    task automatic runSeg(input int pre, input int per, input logic [NUM_CH*CNT_W-1:0] d,
                          input logic [NUM_CH-1:0] pol, input bit md, input int cycles,
                          input int ldAt, input logic [NUM_CH*CNT_W-1:0] d2);
        applyStimulus(1'b0, pre, per, 1'b1, d, pol, md);
        for (int k = 0; k < cycles; k++) begin
            applyStimulus(1'b1, pre, per, (k == ldAt), (k == ldAt) ? d2 : d, pol, md);
        end
    endtask

    function automatic logic [NUM_CH*CNT_W-1:0] packDuty(input int d0, input int d1, input int d2);
        logic [NUM_CH*CNT_W-1:0] v;
        v = '0;
        v[0*CNT_W +: CNT_W] = CNT_W'(d0);
        v[1*CNT_W +: CNT_W] = CNT_W'(d1);
        v[2*CNT_W +: CNT_W] = CNT_W'(d2);
        return v;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("pwm_out", int'(pwm_out), int'(e.pwm));
            checkOutput("period_start", int'(period_start), int'(e.ps));
            checkOutput("duty_pending", int'(duty_pending), int'(e.pend));
        end
    end

    initial begin
        logic [NUM_CH*CNT_W-1:0] rd;
        logic [NUM_CH*CNT_W-1:0] rd2;
        int                      per;
        int                      len;
        reset_n   = 1'b0;
        enable    = 1'b0;
        prescale  = '0;
        period    = '0;
        duty      = '0;
        duty_load = 1'b0;
        polarity  = '0;
        mode      = 1'b0;
        modelReset();
        #2;
        checkOutput("reset_pwm", int'(pwm_out), 0);
        checkOutput("reset_ps", int'(period_start), 0);
        checkOutput("reset_pend", int'(duty_pending), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // 3-high/7-low edge pattern, then a mid-period duty change 3 -> 7.
        runSeg(0, 9, packDuty(3, 5, 0), 3'b000, 1'b0, 34, 14, packDuty(7, 5, 0));
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, 0, 9, 1'b0, packDuty(7, 5, 0), 3'b000, 1'b0);
        // Boundary duties: zero with inverted polarity, and duty above period.
        runSeg(0, 9, packDuty(12, 5, 0), 3'b100, 1'b0, 25, -1, '0);
        // Prescaled: tick every 5 clocks, period of 4 ticks.
        runSeg(4, 3, packDuty(1, 2, 3), 3'b000, 1'b0, 45, -1, '0);
        // Center-aligned when built with the option; edge-aligned otherwise.
        runSeg(0, 4, packDuty(2, 4, 5), 3'b010, 1'b1, 30, -1, '0);
        // Reset with a pending shadow value, then keep running enabled.
        runSeg(0, 9, packDuty(3, 6, 9), 3'b000, 1'b0, 6, 2, packDuty(8, 1, 2));
        pulseReset();
        for (int k = 0; k < 15; k++) applyStimulus(1'b1, 0, 9, 1'b0, packDuty(3, 6, 9), 3'b001, 1'b0);

        for (int s = 0; s < 40; s++) begin
            per = $urandom_range(0, 12);
            rd  = packDuty($urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 14));
            applyStimulus(1'b0, 0, per, ($urandom_range(0, 3) != 0), rd, NUM_CH'($urandom), 1'b0);
            len = $urandom_range(10, 60);
            for (int k = 0; k < len; k++) begin
                rd2 = packDuty($urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 14));
                applyStimulus(1'b1, s % 4, per, ($urandom_range(0, 7) == 0), rd2,
                              NUM_CH'($urandom), 1'(s / 4));
            end
            if ((s % 7) == 3) pulseReset();
        end

        applyStimulus(1'b0, 0, 0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
